lcd_cmd_sched: RTL and testbench

//  Shares the LCD command RAM write port between two requesters: req0 (Wishbone CPU path) and req1 (hardware status updater).

---
 rtl/lcd_cmd_sched_pkg.sv | 17 +
 rtl/lcd_cmd_sched_tick_gen.sv | 24 ++
 rtl/lcd_cmd_sched.sv | 107 ++++++++++
 tb/tb_lcd_cmd_sched.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_cmd_sched_pkg.sv
// Shared types and constants for the LCD command scheduler: command word layout,
// FSM state encoding and the default command-ring placement.
package lcd_pkg;
  localparam int CMD_W   = 24;
  localparam int FIELD_W = 8;
  localparam int ADR_LSB = 16;
  localparam int CTL_LSB = 8;
  localparam int DAT_LSB = 0;

  localparam logic [9:0] RING_BASE  = 10'h14;
  localparam int         RING_DEPTH = 64;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } state_t;
endpackage

// File: rtl/lcd_cmd_sched_tick_gen.sv
// LCD driver pacing: free-running 0..DIV-1 counter, lcd_tick high while it sits at DIV-1.
module lcd_tick_gen #(
  parameter int DIV = 1000
) (
  input  logic clk,
  input  logic reset,
  output logic lcd_tick
);
  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset)
      r_cnt <= '0;
    else if (r_cnt == CNT_LAST)
      r_cnt <= '0;
    else
      r_cnt <= r_cnt + CNT_W'(1);
  end

  assign lcd_tick = (r_cnt == CNT_LAST);
endmodule

// File: rtl/lcd_cmd_sched.sv
// Two-requester writer into the LCD command ring with full/empty tracking and pacing tick.
// Build option: define LCD_SCHED_PRIO_EN for fixed priority (req0 over req1) instead of round-robin.
module lcd_cmd_sched
  import lcd_pkg::*;
#(
  parameter int                ADDR_W = 10,
  parameter logic [ADDR_W-1:0] BASE   = ADDR_W'(RING_BASE),
  parameter int                DEPTH  = RING_DEPTH,
  parameter int                DIV    = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic [CMD_W-1:0]  word0,
  output logic              ack0,
  input  logic              req1,
  input  logic [CMD_W-1:0]  word1,
  output logic              ack1,
  input  logic [ADDR_W-1:0] rd_ptr,
  input  logic              flush,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_adr,
  output logic [CMD_W-1:0]  ram_dat,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic              full,
  output logic              empty,
  output logic              lcd_tick
);
  localparam logic [ADDR_W-1:0] LAST_ADR = BASE + ADDR_W'(DEPTH - 1);

  function automatic logic [ADDR_W-1:0] ring_next(input logic [ADDR_W-1:0] p);
    return (p == LAST_ADR) ? BASE : p + ADDR_W'(1);
  endfunction

  state_t            r_state;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] w_wr_next;
  logic              w_grant;
  logic              w_pick1;
  logic [CMD_W-1:0]  w_word;

  assign w_wr_next = ring_next(r_wr_ptr);
  assign full      = (w_wr_next == rd_ptr);
  assign empty     = (r_wr_ptr == rd_ptr);
  assign wr_ptr    = r_wr_ptr;
  assign w_grant   = (req0 | req1) & ~full;
  assign w_word    = w_pick1 ? word1 : word0;

`ifdef LCD_SCHED_PRIO_EN
  assign w_pick1 = ~req0;
`else
  // r_last_grant: 1 means req1 won most recently, so req0 is favoured next.
  logic r_last_grant;

  assign w_pick1 = (req0 & req1) ? ~r_last_grant : req1;

  always_ff @(posedge clk) begin
    if (reset)
      r_last_grant <= 1'b1;
    else if (r_state == ST_IDLE && !flush && w_grant)
      r_last_grant <= w_pick1;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      ram_we   <= 1'b0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      ram_adr  <= '0;
      ram_dat  <= '0;
      r_wr_ptr <= BASE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (flush) begin
            r_wr_ptr <= BASE;
          end else if (w_grant) begin
            ram_we  <= 1'b1;
            ram_adr <= r_wr_ptr;
            ram_dat <= {w_word[ADR_LSB +: FIELD_W], w_word[CTL_LSB +: FIELD_W],
                        w_word[DAT_LSB +: FIELD_W]};
            ack0    <= ~w_pick1;
            ack1    <= w_pick1;
            r_state <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          ram_we   <= 1'b0;
          ack0     <= 1'b0;
          ack1     <= 1'b0;
          // A flush arriving mid-write lets the word land, then rewinds the ring.
          r_wr_ptr <= flush ? BASE : w_wr_next;
          r_state  <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  lcd_tick_gen #(.DIV(DIV)) u_tick (
    .clk      (clk),
    .reset    (reset),
    .lcd_tick (lcd_tick)
  );
endmodule

// File: tb/tb_lcd_cmd_sched.sv
// Scenario tasks for lcd_cmd_sched plus a randomized run against a transaction-level ring model.
module tb_lcd_cmd_sched;
  localparam int         ADDR_W = 10;
  localparam logic [9:0] BASE   = 10'h14;
  localparam int         DEPTH  = 64;
  localparam int         DIV    = 4;
`ifdef LCD_SCHED_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0, flush = 1'b0;
  logic [23:0] word0 = '0, word1 = '0;
  logic [9:0]  rd_ptr = BASE;
  logic        ack0, ack1, ram_we, full, empty, lcd_tick;
  logic [9:0]  ram_adr, wr_ptr;
  logic [23:0] ram_dat;

  int n_checks = 0;
  int n_fail   = 0;

  lcd_cmd_sched #(.ADDR_W(ADDR_W), .BASE(BASE), .DEPTH(DEPTH), .DIV(DIV)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .word0(word0), .ack0(ack0),
    .req1(req1), .word1(word1), .ack1(ack1),
    .rd_ptr(rd_ptr), .flush(flush),
    .ram_we(ram_we), .ram_adr(ram_adr), .ram_dat(ram_dat),
    .wr_ptr(wr_ptr), .full(full), .empty(empty), .lcd_tick(lcd_tick)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] nxt(input logic [9:0] p);
    return (int'(p) == int'(BASE) + DEPTH - 1) ? BASE : p + 10'd1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; flush = 1'b0; rd_ptr = BASE;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; flush = 1'b0; rd_ptr = BASE;
    step();
    step();
    n_checks++;
    if ({ram_we, ack0, ack1, lcd_tick} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ctrl: got we/ack0/ack1/tick=%b required 0000", {ram_we, ack0, ack1, lcd_tick});
    end
    n_checks++;
    if (ram_adr !== 10'h0 || ram_dat !== 24'h0) begin
      n_fail++; $display("FAIL reset_bus: got adr=%h dat=%h required 000/000000", ram_adr, ram_dat);
    end
    n_checks++;
    if (wr_ptr !== BASE || empty !== 1'b1 || full !== 1'b0) begin
      n_fail++; $display("FAIL reset_ptr: got wr_ptr=%h empty=%b full=%b required 014/1/0", wr_ptr, empty, full);
    end
    reset = 1'b0;
    $display("test_reset: done");
  endtask

  task automatic test_single();
    do_reset();
    word0 = 24'h800141; req0 = 1'b1;
    step();
    n_checks++;
    if ({ram_we, ack0, ack1} !== 3'b110 || ram_adr !== 10'h14 || ram_dat !== 24'h800141) begin
      n_fail++; $display("FAIL single_write: got we/ack0/ack1=%b adr=%h dat=%h required 110/014/800141",
                         {ram_we, ack0, ack1}, ram_adr, ram_dat);
    end
    req0 = 1'b0;
    step();
    n_checks++;
    if ({ram_we, ack0} !== 2'b00 || wr_ptr !== 10'h15 || empty !== 1'b0) begin
      n_fail++; $display("FAIL single_after: got we/ack0=%b wr_ptr=%h empty=%b required 00/015/0",
                         {ram_we, ack0}, wr_ptr, empty);
    end
    $display("test_single: write 800141 -> adr 014");
  endtask

  task automatic test_round_robin();
    int g = 0;
    do_reset();
    word0 = 24'hA0A0A0; word1 = 24'hB1B1B1; req0 = 1'b1; req1 = 1'b1;
    for (int c = 0; c < 40 && g < 4; c++) begin
      step();
      if (ack0 || ack1) begin
        logic exp1;
        exp1 = PRIO ? 1'b0 : g[0];
        n_checks++;
        if ({ack0, ack1} !== {~exp1, exp1} || ram_adr !== BASE + 10'(g) ||
            ram_dat !== (exp1 ? word1 : word0)) begin
          n_fail++; $display("FAIL rr_grant%0d: got ack0/ack1=%b adr=%h dat=%h required %b/%h/%h",
                             g, {ack0, ack1}, ram_adr, ram_dat, {~exp1, exp1}, BASE + 10'(g),
                             exp1 ? word1 : word0);
        end
        g++;
      end
    end
    n_checks++;
    if (g != 4) begin
      n_fail++; $display("FAIL rr_count: got %0d grants required 4 within budget", g);
    end
    req0 = 1'b0; req1 = 1'b0;
    step();
    $display("test_round_robin: %0d grants", g);
  endtask

  task automatic test_full();
    int acks = 0;
    do_reset();
    rd_ptr = 10'h14; req0 = 1'b1; word0 = 24'($urandom);
    for (int c = 0; c < 300 && acks < 63; c++) begin
      step();
      if (ack0) acks++;
    end
    step();
    n_checks++;
    if (acks != 63 || wr_ptr !== 10'h53 || full !== 1'b1) begin
      n_fail++; $display("FAIL full_reach: got acks=%0d wr_ptr=%h full=%b required 63/053/1", acks, wr_ptr, full);
    end
    for (int c = 0; c < 8; c++) begin
      step();
      n_checks++;
      if (ack0 !== 1'b0 || ram_we !== 1'b0) begin
        n_fail++; $display("FAIL full_stall: got ack0=%b we=%b required 0/0", ack0, ram_we);
      end
    end
    rd_ptr = 10'h15;
    step();
    n_checks++;
    if (ack0 !== 1'b1 || ram_we !== 1'b1 || ram_adr !== 10'h53) begin
      n_fail++; $display("FAIL full_resume: got ack0=%b we=%b adr=%h required 1/1/053", ack0, ram_we, ram_adr);
    end
    req0 = 1'b0;
    step();
    n_checks++;
    if (wr_ptr !== 10'h14 || full !== 1'b1) begin
      n_fail++; $display("FAIL full_wrap: got wr_ptr=%h full=%b required 014/1", wr_ptr, full);
    end
    $display("test_full: %0d writes before full, wrap to %h", acks, wr_ptr);
  endtask

  task automatic test_flush();
    bit seen = 1'b0;
    do_reset();
    req0 = 1'b1; word0 = 24'h123456;
    for (int c = 0; c < 100 && !seen; c++) begin
      step();
      if (ack0 && ram_adr == 10'h20) seen = 1'b1;
    end
    n_checks++;
    if (!seen || ram_we !== 1'b1) begin
      n_fail++; $display("FAIL flush_reach: got seen=%b we=%b required 1/1", seen, ram_we);
    end
    flush = 1'b1; req0 = 1'b0;
    step();
    flush = 1'b0;
    n_checks++;
    if (wr_ptr !== 10'h14 || ram_we !== 1'b0) begin
      n_fail++; $display("FAIL flush_write: got wr_ptr=%h we=%b required 014/0", wr_ptr, ram_we);
    end
    req0 = 1'b1;
    step();
    req0 = 1'b0;
    step();
    req0 = 1'b1; flush = 1'b1;
    step();
    n_checks++;
    if ({ram_we, ack0} !== 2'b00 || wr_ptr !== 10'h14) begin
      n_fail++; $display("FAIL flush_idle: got we/ack0=%b wr_ptr=%h required 00/014", {ram_we, ack0}, wr_ptr);
    end
    flush = 1'b0;
    step();
    n_checks++;
    if (ack0 !== 1'b1 || ram_adr !== 10'h14) begin
      n_fail++; $display("FAIL flush_regrant: got ack0=%b adr=%h required 1/014", ack0, ram_adr);
    end
    req0 = 1'b0;
    step();
    $display("test_flush: done");
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    req1 = 1'b1; word1 = 24'hC0FFEE;
    step();
    n_checks++;
    if (ack1 !== 1'b1 || ram_we !== 1'b1 || ram_dat !== 24'hC0FFEE) begin
      n_fail++; $display("FAIL rmw_grant: got ack1=%b we=%b dat=%h required 1/1/c0ffee", ack1, ram_we, ram_dat);
    end
    reset = 1'b1; req1 = 1'b0;
    step();
    n_checks++;
    if ({ram_we, ack0, ack1} !== 3'b000 || wr_ptr !== 10'h14) begin
      n_fail++; $display("FAIL rmw_drop: got we/ack0/ack1=%b wr_ptr=%h required 000/014", {ram_we, ack0, ack1}, wr_ptr);
    end
    reset = 1'b0;
    $display("test_reset_mid_write: done");
  endtask

  task automatic test_tick();
    do_reset();
    for (int c = 0; c < 40; c++) begin
      if (c > 0) step();
      if (c == 20) flush = 1'b1;
      if (c == 22) flush = 1'b0;
      n_checks++;
      if (lcd_tick !== ((c % DIV) == DIV - 1)) begin
        n_fail++; $display("FAIL tick_c%0d: got %b required %b", c, lcd_tick, (c % DIV) == DIV - 1);
      end
    end
    $display("test_tick: done");
  endtask

  task automatic test_random();
    logic [9:0]  m_wr;
    logic        m_writing, m_last, exp_we, exp_a0, exp_a1;
    logic [9:0]  exp_adr;
    logic [23:0] exp_dat;
    int          writes = 0;
    do_reset();
    m_wr = BASE; m_writing = 1'b0; m_last = 1'b1;
    exp_we = 1'b0; exp_a0 = 1'b0; exp_a1 = 1'b0; exp_adr = '0; exp_dat = '0;
    for (int c = 0; c < 3000; c++) begin
      logic full_n, grant, win1;
      n_checks++;
      if ({ram_we, ack0, ack1} !== {exp_we, exp_a0, exp_a1}) begin
        n_fail++; $display("FAIL rnd_ctrl c%0d: got we/ack0/ack1=%b required %b", c, {ram_we, ack0, ack1},
                           {exp_we, exp_a0, exp_a1});
      end
      if (exp_we) begin
        writes++;
        n_checks++;
        if (ram_adr !== exp_adr || ram_dat !== exp_dat) begin
          n_fail++; $display("FAIL rnd_bus c%0d: got adr=%h dat=%h required %h/%h", c, ram_adr, ram_dat, exp_adr, exp_dat);
        end
      end
      n_checks++;
      if (wr_ptr !== m_wr || full !== (nxt(m_wr) == rd_ptr) || empty !== (m_wr == rd_ptr)) begin
        n_fail++; $display("FAIL rnd_ptr c%0d: got wr_ptr=%h full=%b empty=%b required %h/%b/%b", c, wr_ptr, full,
                           empty, m_wr, nxt(m_wr) == rd_ptr, m_wr == rd_ptr);
      end
      // Requesters: drop on ack, otherwise occasionally raise a new word.
      if (exp_a0) req0 = 1'b0;
      else if (!req0 && $urandom_range(3) == 0) begin req0 = 1'b1; word0 = 24'($urandom); end
      if (exp_a1) req1 = 1'b0;
      else if (!req1 && $urandom_range(3) == 0) begin req1 = 1'b1; word1 = 24'($urandom); end
      if ($urandom_range(15) == 0) rd_ptr = BASE + 10'($urandom_range(DEPTH - 1));
      flush = ($urandom_range(63) == 0);
      full_n = (nxt(m_wr) == rd_ptr);
      grant  = !m_writing && (req0 || req1) && !full_n && !flush;
      if (PRIO) win1 = !req0;
      else      win1 = (req0 && req1) ? !m_last : req1;
      exp_we = grant; exp_a0 = grant && !win1; exp_a1 = grant && win1;
      exp_adr = m_wr; exp_dat = win1 ? word1 : word0;
      if (grant) m_last = win1;
      if (m_writing) m_wr = flush ? BASE : nxt(m_wr);
      else if (flush) m_wr = BASE;
      m_writing = grant;
      step();
    end
    req0 = 1'b0; req1 = 1'b0; flush = 1'b0;
    $display("test_random: %0d writes observed", writes);
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_full();
    test_flush();
    test_reset_mid_write();
    test_tick();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
